// File: rtl/bank_dearbiter.sv
// Restores lane order of a 4-bank coefficient read by routing d_i = q[a_i] RD_LAT+1 cycles after the request.
// Optional duplicate-bank detection is compiled in with the BANK_CONFLICT_CHECK_EN macro.
module bank_dearbiter #(
    parameter int DATA_W = 24,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        a0,
    input  logic [1:0]        a1,
    input  logic [1:0]        a2,
    input  logic [1:0]        a3,
    input  logic [DATA_W-1:0] q0,
    input  logic [DATA_W-1:0] q1,
    input  logic [DATA_W-1:0] q2,
    input  logic [DATA_W-1:0] q3,
    output logic              out_valid,
    output logic [DATA_W-1:0] d0,
    output logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] d2,
    output logic [DATA_W-1:0] d3,
    output logic [7:0]        beat_cnt,
    output logic              err_conflict
);

    logic [RD_LAT-1:0]             vld_q, vld_d;
    logic [RD_LAT-1:0][7:0]        sel_q, sel_d;
    logic                          out_valid_q, out_valid_d;
    logic [3:0][DATA_W-1:0]        dat_q, dat_d;
    logic [3:0][DATA_W-1:0]        q_bank;
    logic [7:0]                    beat_cnt_q, beat_cnt_d;
    logic [7:0]                    tail_sel;

    assign q_bank = {q3, q2, q1, q0};

    always_comb begin
        vld_d       = '0;
        sel_d       = '0;
        vld_d[0]    = req_valid;
        sel_d[0]    = {a3, a2, a1, a0};
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            sel_d[i] = sel_q[i-1];
        end
        tail_sel    = sel_q[RD_LAT-1];
        out_valid_d = vld_q[RD_LAT-1];
        dat_d       = dat_q;
        // Bank data is only looked at when a live tag sits in the last stage.
        if (vld_q[RD_LAT-1]) begin
            for (int i = 0; i < 4; i++) begin
                dat_d[i] = q_bank[tail_sel[2*i +: 2]];
            end
        end
        beat_cnt_d  = beat_cnt_q + {7'd0, out_valid_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            dat_q       <= '0;
            beat_cnt_q  <= 8'd0;
        end else begin
            vld_q       <= vld_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            dat_q       <= dat_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign d0        = dat_q[0];
    assign d1        = dat_q[1];
    assign d2        = dat_q[2];
    assign d3        = dat_q[3];
    assign beat_cnt  = beat_cnt_q;

`ifdef BANK_CONFLICT_CHECK_EN
    logic err_q, err_d, dup_a;

    always_comb begin
        dup_a = (a0 == a1) | (a0 == a2) | (a0 == a3) |
                (a1 == a2) | (a1 == a3) | (a2 == a3);
        err_d = err_q | (req_valid & dup_a);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_conflict = err_q;
`else
    assign err_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_bank_dearbiter.sv
// Bench for bank_dearbiter: directed and random requests against a cycle-history reference model.
module tb_bank_dearbiter;

    localparam int DW = 24;
    localparam int L  = 2;
    localparam int N  = 1024;

`ifdef BANK_CONFLICT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [1:0]    a0 = '0, a1 = '0, a2 = '0, a3 = '0;
    logic [DW-1:0] q0 = '0, q1 = '0, q2 = '0, q3 = '0;
    logic          out_valid;
    logic [DW-1:0] d0, d1, d2, d3;
    logic [7:0]    beat_cnt;
    logic          err_conflict;

    bank_dearbiter #(.DATA_W(DW), .RD_LAT(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .out_valid(out_valid),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .beat_cnt(beat_cnt), .err_conflict(err_conflict)
    );

    always #5 clk = ~clk;

    // Per-cycle record of what was driven; the model reads it back by cycle index.
    logic          rst_h [N];
    logic          req_h [N];
    logic [7:0]    a_h   [N];
    logic [DW-1:0] q_h   [N][4];

    int            t;
    int            n_vec, n_err, ov_seen;
    logic          m_ov, m_ov_prev, m_err;
    logic [4*DW-1:0] m_d;
    logic [7:0]    m_bc;
    logic          o_ov, o_err;
    logic [4*DW-1:0] o_d;
    logic [7:0]    o_bc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit dup(input logic [7:0] av);
        return (av[1:0] == av[3:2]) || (av[1:0] == av[5:4]) || (av[1:0] == av[7:6]) ||
               (av[3:2] == av[5:4]) || (av[3:2] == av[7:6]) || (av[5:4] == av[7:6]);
    endfunction

    function automatic logic [7:0] rperm();
        logic [1:0] p [4];
        logic [1:0] tmp;
        for (int i = 0; i < 4; i++) p[i] = 2'(i);
        for (int i = 3; i > 0; i--) begin
            int j = int'($urandom_range(i, 0));
            tmp = p[i]; p[i] = p[j]; p[j] = tmp;
        end
        return {p[3], p[2], p[1], p[0]};
    endfunction

    function automatic logic [4*DW-1:0] rq4();
        return {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
    endfunction

    // Drive one cycle, advance the reference model, check at the falling edge.
    task automatic cyc(input logic r, input logic rv, input logic [7:0] av, input logic [4*DW-1:0] qv);
        bit ok;
        rst = r; req_valid = rv;
        a0 = av[1:0]; a1 = av[3:2]; a2 = av[5:4]; a3 = av[7:6];
        q0 = qv[0*DW +: DW]; q1 = qv[1*DW +: DW]; q2 = qv[2*DW +: DW]; q3 = qv[3*DW +: DW];
        rst_h[t] = r; req_h[t] = rv; a_h[t] = av;
        for (int i = 0; i < 4; i++) q_h[t][i] = qv[i*DW +: DW];

        if (r) begin
            m_ov = 1'b0; m_d = '0; m_bc = 8'd0; m_err = 1'b0;
        end else begin
            m_bc = m_bc + {7'd0, m_ov_prev};
            ok = (t >= L + 1);
            if (ok) begin
                for (int k = t - L - 1; k < t; k++) if (rst_h[k]) ok = 1'b0;
            end
            m_ov = ok && req_h[t-L-1];
            if (m_ov) begin
                for (int i = 0; i < 4; i++) m_d[i*DW +: DW] = q_h[t-1][a_h[t-L-1][2*i +: 2]];
            end
`ifdef BANK_CONFLICT_CHECK_EN
            if (t >= 1 && req_h[t-1] && !rst_h[t-1] && dup(a_h[t-1])) m_err = 1'b1;
`endif
        end
        m_ov_prev = m_ov;

        @(negedge clk);
        o_ov = out_valid; o_d = {d3, d2, d1, d0}; o_bc = beat_cnt; o_err = err_conflict;
        if (o_ov === 1'b1) ov_seen++;
        chk("out_valid", o_ov, m_ov);
        chk("d", o_d, m_d);
        chk("beat_cnt", o_bc, m_bc);
        chk("err_conflict", o_err, m_err);
        @(posedge clk);
        #1;
        t++;
    endtask

    initial begin
        t = 0; n_vec = 0; n_err = 0; ov_seen = 0;
        m_ov = 1'b0; m_ov_prev = 1'b0; m_err = 1'b0; m_d = '0; m_bc = 8'd0;
        @(posedge clk);
        #1;

        // Reset state, with a request offered during reset that must be dropped.
        cyc(1'b1, 1'b1, rperm(), rq4());
        cyc(1'b1, 1'b0, rperm(), rq4());
        chk("rst_ov", o_ov, 1'b0);
        chk("rst_d", o_d, '0);
        chk("rst_bc", o_bc, 8'd0);
        cyc(1'b0, 1'b0, rperm(), rq4());
        cyc(1'b0, 1'b0, rperm(), rq4());
        cyc(1'b0, 1'b0, rperm(), rq4());
        chk("rst_drop", ov_seen, 0);

        // Identity permutation.
        cyc(1'b0, 1'b1, {2'd3, 2'd2, 2'd1, 2'd0}, rq4());
        cyc(1'b0, 1'b0, rperm(), rq4());
        cyc(1'b0, 1'b0, rperm(), {24'h0000DD, 24'h0000CC, 24'h0000BB, 24'h0000AA});
        cyc(1'b0, 1'b0, rperm(), rq4());
        chk("id_ov", o_ov, 1'b1);
        chk("id_d", o_d, {24'h0000DD, 24'h0000CC, 24'h0000BB, 24'h0000AA});
        cyc(1'b0, 1'b0, rperm(), rq4());
        chk("id_hold", o_d, {24'h0000DD, 24'h0000CC, 24'h0000BB, 24'h0000AA});

        // Rotation a=(3,0,1,2), q=(10,11,12,13) -> d=(13,10,11,12).
        cyc(1'b0, 1'b1, {2'd2, 2'd1, 2'd0, 2'd3}, rq4());
        cyc(1'b0, 1'b0, rperm(), rq4());
        cyc(1'b0, 1'b0, rperm(), {24'd13, 24'd12, 24'd11, 24'd10});
        cyc(1'b0, 1'b0, rperm(), rq4());
        chk("rot_ov", o_ov, 1'b1);
        chk("rot_d", o_d, {24'd12, 24'd11, 24'd10, 24'd13});

        // 300 back-to-back random permutations from a clean counter.
        cyc(1'b1, 1'b0, rperm(), rq4());
        ov_seen = 0;
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, rperm(), rq4());
        for (int i = 0; i < L + 2; i++) cyc(1'b0, 1'b0, rperm(), rq4());
        chk("stream_beats", ov_seen, 300);
        chk("stream_bc", o_bc, 8'd44);

        // Reset while a request is in flight.
        ov_seen = 0;
        cyc(1'b0, 1'b1, rperm(), rq4());
        cyc(1'b1, 1'b0, rperm(), rq4());
        cyc(1'b0, 1'b0, rperm(), rq4());
        cyc(1'b0, 1'b0, rperm(), rq4());
        chk("mr_no_ov", o_ov, 1'b0);
        cyc(1'b0, 1'b1, rperm(), rq4());
        cyc(1'b0, 1'b0, rperm(), rq4());
        cyc(1'b0, 1'b0, rperm(), rq4());
        cyc(1'b0, 1'b0, rperm(), rq4());
        chk("mr_ov", o_ov, 1'b1);
        cyc(1'b0, 1'b0, rperm(), rq4());
        chk("mr_single", ov_seen, 1);

        // Duplicate bank numbers a=(1,1,2,3).
        cyc(1'b1, 1'b0, rperm(), rq4());
        cyc(1'b0, 1'b1, {2'd3, 2'd2, 2'd1, 2'd1}, rq4());
        cyc(1'b0, 1'b0, rperm(), rq4());
        chk("conf_err", o_err, EXP_ERR);
        cyc(1'b0, 1'b0, rperm(), {24'h300003, 24'h200002, 24'h100001, 24'h000000});
        cyc(1'b0, 1'b0, rperm(), rq4());
        chk("conf_d0", o_d[0*DW +: DW], 24'h100001);
        chk("conf_d1", o_d[1*DW +: DW], 24'h100001);
        chk("conf_d3", o_d[3*DW +: DW], 24'h300003);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, rperm(), rq4());
        chk("conf_sticky", o_err, EXP_ERR);
        cyc(1'b1, 1'b0, rperm(), rq4());
        chk("conf_clr", o_err, 1'b0);

        // Random mix: sparse requests, arbitrary bank sets, occasional resets.
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(29, 0) == 0), 1'($urandom), 8'($urandom), rq4());
        end
        for (int i = 0; i < L + 2; i++) cyc(1'b0, 1'b0, rperm(), rq4());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bank_dearbiter.md
BANK_DEARBITER -- requirements
Module: bank_dearbiter

Interface
REQ-001 Parameter DATA_W, default 24, SHALL set the coefficient width of every data port.
REQ-002 Parameter RD_LAT, default 2, legal range 1..8, SHALL set the bank read latency in cycles.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid  input  1  SHALL mark a cycle in which a 4-lane bank read is issued.
REQ-006 a0,a1,a2,a3  input  2 each  SHALL give the bank number that lane i's coefficient was read from.
REQ-007 q0,q1,q2,q3  input  DATA_W each  SHALL carry the read data of bank 0..3, valid RD_LAT cycles after the matching req_valid.
REQ-008 out_valid  output  1  SHALL mark a cycle in which d0..d3 hold a restored lane-ordered beat.
REQ-009 d0,d1,d2,d3  output  DATA_W each  SHALL carry the coefficient for lanes 0..3.
REQ-010 beat_cnt  output  8  SHALL count beats delivered on out_valid.
REQ-011 err_conflict  output  1  SHALL be a sticky flag for a non-distinct bank-number set.

Function
REQ-012 The block SHALL invert the read-side bank permutation: d_i SHALL equal q[a_i], using the a_i captured with the matching request.
REQ-013 A tag pipeline of RD_LAT stages SHALL carry {valid, a0..a3} and SHALL shift every cycle without stalls.
REQ-014 In the cycle the tag reaches stage RD_LAT, the block SHALL sample q0..q3 and SHALL register the routed result into d0..d3.
REQ-015 Latency SHALL be exactly RD_LAT+1 cycles from the req_valid edge to the out_valid edge.
REQ-016 Back-to-back requests SHALL produce back-to-back out_valid with no bubbles, giving a throughput of 1 beat per cycle.
REQ-017 When out_valid is 0, d0..d3 SHALL hold their previous values.
REQ-018 Bank-number fields of stages whose valid bit is 0 SHALL be ignored.
REQ-019 beat_cnt SHALL increment by 1 for each out_valid cycle and SHALL wrap from 255 to 0.
REQ-020 The block SHALL be a pipeline only and SHALL have no FSM beyond the tag shift register.
REQ-021 q0..q3 SHALL be sampled only in the cycles given by REQ-014.

Reset
REQ-022 On rst=1, all tag valid bits SHALL clear immediately and in-flight requests SHALL be discarded.
REQ-023 On rst=1, out_valid SHALL be 0, d0..d3 SHALL be 0, beat_cnt SHALL be 0 and err_conflict SHALL be 0.
REQ-024 A req_valid asserted in a cycle where rst is high SHALL be dropped.
REQ-025 Normal operation SHALL resume on the first rising edge after rst deasserts.
REQ-026 The first out_valid after a mid-stream reset SHALL come from a request issued after the reset.

Configuration
REQ-027 Macro BANK_CONFLICT_CHECK_EN SHALL enable duplicate-bank checking.
REQ-028 When BANK_CONFLICT_CHECK_EN is defined, any req_valid cycle whose a0..a3 are not all distinct SHALL set err_conflict on the next edge.
REQ-029 err_conflict SHALL then hold 1 until rst.
REQ-030 A conflicting beat SHALL still be routed per REQ-012.
REQ-031 When BANK_CONFLICT_CHECK_EN is undefined, err_conflict SHALL be constant 0 and no check logic SHALL be present.

Verification
REQ-032 Identity: RD_LAT=2, req at cycle 0 with a=(0,1,2,3) and q=(A,B,C,D) at cycle 2 -> at cycle 3 out_valid=1 and d=(A,B,C,D).
REQ-033 Rotation: a=(3,0,1,2) and q=(10,11,12,13) -> d=(13,10,11,12).
REQ-034 Streaming: 300 consecutive requests with random permutations -> 300 consecutive out_valid beats, all matching the model, and beat_cnt=44 (300 mod 256).
REQ-035 Reset mid-flight: req at cycle 0, rst pulse at cycle 1, req at cycle 4 -> no out_valid at cycle 3 and a single out_valid at cycle 7.
REQ-036 Conflict with macro defined: a=(1,1,2,3) -> err_conflict=1 from the next edge until rst, and d0=d1=q1.
REQ-037 Conflict with macro undefined: a=(1,1,2,3) -> err_conflict stays 0.
